wash_phase_timer: RTL



---
 rtl/wash_pkg.sv | 25 ++
 rtl/tick_prescaler.sv | 37 +++
 rtl/wash_phase_timer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wash_pkg.sv
// Shared types and per-program phase durations (in prescaled ticks) for wash_phase_timer.
package wash_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ARMED   = 3'd1,
        PH_WASH    = 3'd2,
        PH_RINSE   = 3'd3,
        PH_SPIN    = 3'd4,
        PH_EXPIRED = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        PROG_QUICK      = 2'd0,
        PROG_NORMAL     = 2'd1,
        PROG_HEAVY      = 2'd2,
        PROG_RINSE_ONLY = 2'd3
    } prog_e;

    // Indexed by prog_e: QUICK, NORMAL, HEAVY, RINSE_ONLY.
    localparam int unsigned WASH_TICKS  [4] = '{2, 3, 5, 0};
    localparam int unsigned RINSE_TICKS [4] = '{1, 2, 4, 2};
    localparam int unsigned SPIN_TICKS  [4] = '{1, 2, 3, 2};

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by TICK_DIV into a single-cycle tick; clr restarts the count, hold freezes it.
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer beside the washing-machine FSM: times wash/rinse/spin and raises held timeout flags.
// Optional WASH_PHASE_TIMER_CFG_EN adds a runtime-writable duration register replacing the table.
module wash_phase_timer
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             pause,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             drain_value_on,
    input  logic             motor_on,
`ifdef WASH_PHASE_TIMER_CFG_EN
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_ticks,
`endif
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             busy
);

    function automatic logic [CNT_W-1:0] sat_ticks(input int unsigned v);
        longint unsigned lim;
        lim = (64'd1 << CNT_W) - 64'd1;
        if (64'(v) > lim) return '1;
        return CNT_W'(v);
    endfunction

    phase_e           state_q, state_d, src_q, src_d;
    prog_e            prog_q, prog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_q, cyc_d, spin_q, spin_d;
    logic             load, tick, counting, phase_in;
    logic [CNT_W-1:0] wash_len, rinse_len, spin_len;
    logic [CNT_W-1:0] wash_tab [4];
    logic [CNT_W-1:0] rinse_tab [4];
    logic [CNT_W-1:0] spin_tab [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_tab
        assign wash_tab[gi]  = sat_ticks(WASH_TICKS[gi]);
        assign rinse_tab[gi] = sat_ticks(RINSE_TICKS[gi]);
        assign spin_tab[gi]  = sat_ticks(SPIN_TICKS[gi]);
    end

`ifdef WASH_PHASE_TIMER_CFG_EN
    logic [CNT_W-1:0] cfg_q [3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q[0] <= sat_ticks(WASH_TICKS[PROG_NORMAL]);
            cfg_q[1] <= sat_ticks(RINSE_TICKS[PROG_NORMAL]);
            cfg_q[2] <= sat_ticks(SPIN_TICKS[PROG_NORMAL]);
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    cfg_q[0] <= cfg_ticks;
                2'd1:    cfg_q[1] <= cfg_ticks;
                2'd2:    cfg_q[2] <= cfg_ticks;
                default: ;
            endcase
        end
    end

    assign wash_len  = cfg_q[0];
    assign rinse_len = cfg_q[1];
    assign spin_len  = cfg_q[2];
`else
    assign wash_len  = wash_tab[prog_q];
    assign rinse_len = rinse_tab[prog_q];
    assign spin_len  = spin_tab[prog_q];
`endif

    assign counting = (state_q == PH_WASH) || (state_q == PH_RINSE) || (state_q == PH_SPIN);

    // In EXPIRED the phase that timed out decides which input releases the flag.
    always_comb begin
        phase_e sel;
        sel      = (state_q == PH_EXPIRED) ? src_q : state_q;
        phase_in = 1'b0;
        case (sel)
            PH_WASH:  phase_in = soap_wash;
            PH_RINSE: phase_in = water_wash;
            PH_SPIN:  phase_in = drain_value_on && motor_on;
            default:  phase_in = 1'b0;
        endcase
    end

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (load),
        .hold_i (pause || !counting),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        spin_d  = spin_q;
        load    = 1'b0;
        if (!pause) begin
            case (state_q)
                PH_IDLE: begin
                    if (start) begin
                        prog_d  = prog_e'(prog_sel);
                        state_d = PH_ARMED;
                    end
                end
                PH_ARMED: begin
                    if (soap_wash) begin
                        state_d = PH_WASH;
                        cnt_d   = wash_len;
                        load    = 1'b1;
                    end else if (water_wash) begin
                        state_d = PH_RINSE;
                        cnt_d   = rinse_len;
                        load    = 1'b1;
                    end else if (drain_value_on && motor_on) begin
                        state_d = PH_SPIN;
                        cnt_d   = spin_len;
                        load    = 1'b1;
                    end
                end
                PH_WASH, PH_RINSE, PH_SPIN: begin
                    // An abort wins over an expiry landing on the same edge.
                    if (!phase_in) begin
                        state_d = PH_ARMED;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = PH_EXPIRED;
                        src_d   = state_q;
                        cyc_d   = (state_q != PH_SPIN);
                        spin_d  = (state_q == PH_SPIN);
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                PH_EXPIRED: begin
                    if (!phase_in) begin
                        state_d = (src_q == PH_SPIN) ? PH_IDLE : PH_ARMED;
                        cyc_d   = 1'b0;
                        spin_d  = 1'b0;
                    end
                end
                default: state_d = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PH_IDLE;
            prog_q  <= PROG_QUICK;
            src_q   <= PH_IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            spin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            spin_q  <= spin_d;
        end
    end

    assign cycle_timeout = cyc_q;
    assign spin_timeout  = spin_q;
    assign phase         = state_q;
    assign remaining     = counting ? cnt_q : '0;
    assign busy          = (state_q != PH_IDLE);

endmodule
